// File: rtl/clint_ctrl_pkg.sv
// Shared definitions for the core-local interrupt controller: CSR addresses,
// mcause codes, mstatus bit positions and the sequencer state encoding.
package clint_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

  localparam logic [31:0] CAUSE_BREAKPOINT  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
  localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MSTATUS,
    ST_W_MCAUSE,
    ST_M_RESTORE,
    ST_JUMP
  } clint_state_e;

  // CSR write port carries a 32-bit address with the upper 20 bits zero.
  function automatic logic [31:0] csr_addr(input logic [11:0] a);
    return {20'h0_0000, a};
  endfunction

endpackage

// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: sequences trap entry / mret through the CSR
// write port. Optional macro CLINT_VECTORED_EN enables vectored async traps.
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter logic [31:0] CAUSE_IRQ = CAUSE_M_TIMER_IRQ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        csr_wr_en_o,
  output logic [31:0] csr_wr_addr_o,
  output logic [31:0] csr_data_o,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  clint_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cause_q, cause_d;
  logic         mret_q, mret_d;

  logic         sync_exc;
  logic         irq_take;
  logic         accept;
  logic [31:0]  trap_vec;

  always_comb begin
    sync_exc = ecall_i | ebreak_i;
    irq_take = irq_i & global_int_en_i;
    accept   = (state_q == ST_IDLE) & ~rst & (sync_exc | mret_i | irq_take);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    case (state_q)
      ST_IDLE: begin
        if (sync_exc) begin
          state_d = ST_W_MEPC;
          pc_d    = inst_addr_i;
          cause_d = ecall_i ? CAUSE_ECALL_M : CAUSE_BREAKPOINT;
          mret_d  = 1'b0;
        end else if (mret_i) begin
          state_d = ST_M_RESTORE;
          mret_d  = 1'b1;
        end else if (irq_take) begin
          // An irq landing on a taken branch must return to the branch target.
          state_d = ST_W_MEPC;
          pc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = CAUSE_IRQ;
          mret_d  = 1'b0;
        end
      end
      ST_W_MEPC:    state_d = ST_W_MSTATUS;
      ST_W_MSTATUS: state_d = ST_W_MCAUSE;
      ST_W_MCAUSE:  state_d = ST_JUMP;
      ST_M_RESTORE: state_d = ST_JUMP;
      ST_JUMP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

`ifdef CLINT_VECTORED_EN
  always_comb begin
    trap_vec = {csr_mtvec_i[31:2], 2'b00};
    if ((csr_mtvec_i[1:0] == 2'b01) && cause_q[31]) begin
      trap_vec = trap_vec + {cause_q[29:0], 2'b00};
    end
  end
`else
  always_comb begin
    trap_vec = csr_mtvec_i;
  end
`endif

  always_comb begin
    csr_wr_en_o   = 1'b0;
    csr_wr_addr_o = '0;
    csr_data_o    = '0;
    int_assert_o  = 1'b0;
    int_addr_o    = '0;
    hold_o        = accept | (state_q != ST_IDLE);
    case (state_q)
      ST_W_MEPC: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = csr_addr(CSR_MEPC);
        csr_data_o    = pc_q;
      end
      ST_W_MSTATUS: begin
        csr_wr_en_o              = 1'b1;
        csr_wr_addr_o            = csr_addr(CSR_MSTATUS);
        csr_data_o               = csr_mstatus_i;
        csr_data_o[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
        csr_data_o[MSTATUS_MIE]  = 1'b0;
      end
      ST_W_MCAUSE: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = csr_addr(CSR_MCAUSE);
        csr_data_o    = cause_q;
      end
      ST_M_RESTORE: begin
        csr_wr_en_o              = 1'b1;
        csr_wr_addr_o            = csr_addr(CSR_MSTATUS);
        csr_data_o               = csr_mstatus_i;
        csr_data_o[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
        csr_data_o[MSTATUS_MPIE] = 1'b1;
      end
      ST_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : trap_vec;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Self-checking bench for clint_ctrl: directed scenarios then randomized
// traffic, all checked against a scheduled-action reference model.
module tb_clint_ctrl;

  localparam logic [31:0] IRQ_CAUSE = 32'h8000_0007;
`ifdef CLINT_VECTORED_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall_i, ebreak_i, mret_i, irq_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        csr_wr_en_o;
  logic [31:0] csr_wr_addr_o, csr_data_o;
  logic        hold_o, int_assert_o;
  logic [31:0] int_addr_o;

  clint_ctrl #(.CAUSE_IRQ(IRQ_CAUSE)) dut (
    .clk            (clk),
    .rst            (rst),
    .ecall_i        (ecall_i),
    .ebreak_i       (ebreak_i),
    .mret_i         (mret_i),
    .irq_i          (irq_i),
    .inst_addr_i    (inst_addr_i),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .global_int_en_i(global_int_en_i),
    .csr_mtvec_i    (csr_mtvec_i),
    .csr_mepc_i     (csr_mepc_i),
    .csr_mstatus_i  (csr_mstatus_i),
    .csr_wr_en_o    (csr_wr_en_o),
    .csr_wr_addr_o  (csr_wr_addr_o),
    .csr_data_o     (csr_data_o),
    .hold_o         (hold_o),
    .int_assert_o   (int_assert_o),
    .int_addr_o     (int_addr_o)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted event schedules the actions of the
  // following cycles; 1 mepc, 2 mstatus save, 3 mcause, 4 mstatus restore,
  // 5 jump to trap vector, 6 jump to mepc.
  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] cause;
  } act_t;

  act_t sched[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic        e_wr, e_hold, e_int;
  logic [31:0] e_addr, e_data, e_iaddr;

  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
    if (!VECTORED) return tvec;
    if ((tvec % 4) == 1 && cause >= 32'h8000_0000)
      return (tvec & ~32'h3) + (cause - 32'h8000_0000) * 32'd4;
    return tvec & ~32'h3;
  endfunction

  function automatic logic [31:0] ms_save(input logic [31:0] m);
    return (m & ~32'h88) | (((m >> 3) & 32'h1) << 7);
  endfunction

  function automatic logic [31:0] ms_restore(input logic [31:0] m);
    return (m & ~32'h8) | 32'h80 | (((m >> 7) & 32'h1) << 3);
  endfunction

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause);
    for (int k = 1; k <= 3; k++) sched.push_back('{k, pc, cause});
    sched.push_back('{5, pc, cause});
  endtask

  task automatic model_cycle();
    act_t a;
    e_wr = 1'b0; e_addr = '0; e_data = '0; e_hold = 1'b0; e_int = 1'b0; e_iaddr = '0;
    if (sched.size() == 0) begin
      if (!rst) begin
        if (ecall_i || ebreak_i) begin
          push_trap(inst_addr_i, ecall_i ? 32'd11 : 32'd3);
          e_hold = 1'b1;
        end else if (mret_i) begin
          sched.push_back('{4, 32'h0, 32'h0});
          sched.push_back('{6, 32'h0, 32'h0});
          e_hold = 1'b1;
        end else if (irq_i && global_int_en_i) begin
          push_trap(jump_flag_i ? jump_addr_i : inst_addr_i, IRQ_CAUSE);
          e_hold = 1'b1;
        end
      end
    end else begin
      a = sched.pop_front();
      e_hold = 1'b1;
      case (a.kind)
        1: begin e_wr = 1'b1; e_addr = 32'h341; e_data = a.pc; end
        2: begin e_wr = 1'b1; e_addr = 32'h300; e_data = ms_save(csr_mstatus_i); end
        3: begin e_wr = 1'b1; e_addr = 32'h342; e_data = a.cause; end
        4: begin e_wr = 1'b1; e_addr = 32'h300; e_data = ms_restore(csr_mstatus_i); end
        5: begin e_int = 1'b1; e_iaddr = trap_target(csr_mtvec_i, a.cause); end
        default: begin e_int = 1'b1; e_iaddr = csr_mepc_i; end
      endcase
    end
    if (rst) sched.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic eval(input string tag);
    #1;
    model_cycle();
    chk({tag, "/hold"},     {31'b0, hold_o},       {31'b0, e_hold});
    chk({tag, "/wr_en"},    {31'b0, csr_wr_en_o},  {31'b0, e_wr});
    chk({tag, "/wr_addr"},  csr_wr_addr_o,         e_addr);
    chk({tag, "/wr_data"},  csr_data_o,            e_data);
    chk({tag, "/assert"},   {31'b0, int_assert_o}, {31'b0, e_int});
    chk({tag, "/int_addr"}, int_addr_o,            e_iaddr);
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    eval(tag);
    adv();
  endtask

  logic [31:0] tmp;

  initial begin
    rst = 1'b1; ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0;
    inst_addr_i = '0; jump_flag_i = 1'b0; jump_addr_i = '0; global_int_en_i = 1'b0;
    csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0;
    repeat (2) adv();

    // Reset state; an ecall held during reset must not raise hold.
    ecall_i = 1'b1;
    step("reset");
    ecall_i = 1'b0; rst = 1'b0;
    step("idle");

    // ecall example.
    inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h400; ecall_i = 1'b1;
    step("ecall_T");
    ecall_i = 1'b0;
    eval("ecall_T1");
    chk("ecall_mepc_addr", csr_wr_addr_o, 32'h341);
    chk("ecall_mepc_data", csr_data_o, 32'h100);
    adv();
    eval("ecall_T2");
    chk("ecall_mstatus_addr", csr_wr_addr_o, 32'h300);
    chk("ecall_mstatus_data", csr_data_o, 32'h80);
    adv();
    eval("ecall_T3");
    chk("ecall_mcause_data", csr_data_o, 32'd11);
    adv();
    eval("ecall_T4");
    chk("ecall_redirect", int_addr_o, 32'h400);
    adv();
    step("ecall_T5");

    // Masked irq is ignored, then taken on a branch target.
    irq_i = 1'b1; global_int_en_i = 1'b0; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
    inst_addr_i = 32'h120;
    repeat (3) begin
      eval("irq_masked");
      chk("irq_masked_hold", {31'b0, hold_o}, 32'h0);
      adv();
    end
    global_int_en_i = 1'b1;
    step("irq_T");
    irq_i = 1'b0; global_int_en_i = 1'b0; jump_flag_i = 1'b0;
    eval("irq_T1");
    chk("irq_mepc_data", csr_data_o, 32'h200);
    adv();
    step("irq_T2");
    eval("irq_T3");
    chk("irq_mcause_data", csr_data_o, 32'h8000_0007);
    adv();
    step("irq_T4");
    step("irq_T5");

    // mret example.
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; mret_i = 1'b1;
    step("mret_T");
    mret_i = 1'b0;
    eval("mret_T1");
    chk("mret_mstatus_data", csr_data_o, 32'h88);
    adv();
    eval("mret_T2");
    chk("mret_redirect", int_addr_o, 32'h104);
    adv();
    step("mret_T3");

    // mret together with irq: mret first, irq right after JUMP.
    mret_i = 1'b1; irq_i = 1'b1; global_int_en_i = 1'b0; inst_addr_i = 32'h300;
    step("mirq_T");
    mret_i = 1'b0;
    step("mirq_T1");
    global_int_en_i = 1'b1;
    step("mirq_T2");
    eval("mirq_T3");
    chk("mirq_irq_accept", {31'b0, hold_o}, 32'h1);
    adv();
    irq_i = 1'b0; global_int_en_i = 1'b0;
    eval("mirq_T4");
    chk("mirq_mepc_addr", csr_wr_addr_o, 32'h341);
    adv();
    repeat (5) step("mirq_tail");

    // Simultaneous ecall and ebreak: ecall cause wins.
    ecall_i = 1'b1; ebreak_i = 1'b1;
    step("both_T");
    ecall_i = 1'b0; ebreak_i = 1'b0;
    step("both_T1");
    step("both_T2");
    eval("both_T3");
    chk("both_cause", csr_data_o, 32'd11);
    adv();
    repeat (2) step("both_tail");

    // Reset while in W_MSTATUS aborts the sequence.
    ecall_i = 1'b1;
    step("rstmid_T");
    ecall_i = 1'b0;
    step("rstmid_T1");
    rst = 1'b1;
    step("rstmid_T2");
    rst = 1'b0;
    eval("rstmid_T3");
    chk("rstmid_hold", {31'b0, hold_o}, 32'h0);
    chk("rstmid_wr_en", {31'b0, csr_wr_en_o}, 32'h0);
    adv();
    repeat (4) step("rstmid_tail");

    // Vector mode in mtvec[1:0].
    csr_mtvec_i = 32'h401; irq_i = 1'b1; global_int_en_i = 1'b1;
    step("vec_irq_T");
    irq_i = 1'b0; global_int_en_i = 1'b0;
    repeat (3) step("vec_irq_w");
    eval("vec_irq_T4");
    chk("vec_irq_target", int_addr_o, VECTORED ? 32'h41C : 32'h401);
    adv();
    ecall_i = 1'b1;
    step("vec_ecall_T");
    ecall_i = 1'b0;
    repeat (3) step("vec_ecall_w");
    eval("vec_ecall_T4");
    chk("vec_ecall_target", int_addr_o, VECTORED ? 32'h400 : 32'h401);
    adv();
    step("vec_idle");

    // Randomized traffic; CSR inputs change every cycle.
    for (int i = 0; i < 3000; i++) begin
      ecall_i         = ($urandom_range(0, 9) == 0);
      ebreak_i        = ($urandom_range(0, 9) == 0);
      mret_i          = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) irq_i = ~irq_i;
      global_int_en_i = ($urandom_range(0, 1) == 1);
      jump_flag_i     = ($urandom_range(0, 1) == 1);
      jump_addr_i     = $urandom;
      inst_addr_i     = $urandom;
      csr_mepc_i      = $urandom;
      csr_mstatus_i   = $urandom;
      tmp             = $urandom;
      csr_mtvec_i     = {tmp[31:2], 1'b0, tmp[0]};
      rst             = ($urandom_range(0, 199) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
